// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops words from a FIFO and sends them LSB byte first as back-to-back UART frames
module fifo_uart_tx #(
  parameter int N_BITS       = 64,
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_EN    = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              fifo_empty,
  input  logic [N_BITS-1:0] fifo_data,
  output logic              fifo_pop,
  output logic              tx,
  output logic              busy,
  output logic              word_done
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(N_BITS / 8) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BYTE = BW'(N_BITS / 8 - 1);
  if (N_BITS % 8 != 0) begin : g_nbits_err
    $error("N_BITS must be a multiple of 8");
  end
  if (CLKS_PER_BIT < 2) begin : g_cpb_err
    $error("CLKS_PER_BIT must be >= 2");
  end
  typedef enum logic [2:0] {IDLE, POP, LOAD, START, DATA, PARITY, STOP, DONE} state_t;
  state_t            state;
  logic [CW-1:0]     cnt;
  logic [2:0]        bit_cnt;
  logic [BW-1:0]     byte_cnt;
  logic [N_BITS-1:0] sh;
  logic [7:0]        cur;
  logic              last;
  assign cur  = sh[7:0];
  assign last = cnt == CNT_MAX;
  // Outputs are loaded alongside each state transition so they are plain flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      byte_cnt  <= '0;
      sh        <= '0;
      tx        <= 1'b1;
      fifo_pop  <= 1'b0;
      busy      <= 1'b0;
      word_done <= 1'b0;
    end else begin
      fifo_pop  <= 1'b0;
      word_done <= 1'b0;
      case (state)
        IDLE: if (enable && !fifo_empty) begin
          state    <= POP;
          fifo_pop <= 1'b1;
          busy     <= 1'b1;
        end
        POP: state <= LOAD;
        LOAD: begin
          sh       <= fifo_data;
          byte_cnt <= '0;
          cnt      <= '0;
          tx       <= 1'b0;
          state    <= START;
        end
        START: if (last) begin
          cnt     <= '0;
          bit_cnt <= '0;
          tx      <= cur[0];
          state   <= DATA;
        end else cnt <= cnt + 1'b1;
        DATA: if (last) begin
          cnt <= '0;
          if (bit_cnt == 3'd7) begin
            state <= PARITY_EN ? PARITY : STOP;
            tx    <= PARITY_EN ? ^cur : 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 3'd1;
            tx      <= cur[bit_cnt + 3'd1];
          end
        end else cnt <= cnt + 1'b1;
        PARITY: if (last) begin
          cnt   <= '0;
          tx    <= 1'b1;
          state <= STOP;
        end else cnt <= cnt + 1'b1;
        STOP: if (last) begin
          cnt <= '0;
          if (byte_cnt == LAST_BYTE) begin
            word_done <= 1'b1;
            state     <= DONE;
          end else begin
            byte_cnt <= byte_cnt + 1'b1;
            sh       <= sh >> 8;
            tx       <= 1'b0;
            state    <= START;
          end
        end else cnt <= cnt + 1'b1;
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: directed checks of fifo_uart_tx, one plain and one parity instance on a shared FIFO model
module tb_fifo_uart_tx;
  localparam int CPB = 4;
  logic clk = 1'b0, rst_n = 1'b0, en0 = 1'b0, en1 = 1'b0;
  logic pop0, pop1, tx0, tx1, busy0, busy1, wd0, wd1, fifo_empty;
  logic [15:0] fifo_data = '0;
  logic [15:0] mem [64];
  int wr = 0, rd = 0, cyc = 0;
  int checks = 0, errors = 0;
  int pops0 = 0, pops1 = 0, wds0 = 0, wds1 = 0, low0 = 0, viol = 0, pop_cyc = 0;
  fifo_uart_tx #(.N_BITS(16), .CLKS_PER_BIT(CPB), .PARITY_EN(0)) dut (
    .clk(clk), .rst_n(rst_n), .enable(en0), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_pop(pop0), .tx(tx0), .busy(busy0), .word_done(wd0));
  fifo_uart_tx #(.N_BITS(16), .CLKS_PER_BIT(CPB), .PARITY_EN(1)) dut_p (
    .clk(clk), .rst_n(rst_n), .enable(en1), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_pop(pop1), .tx(tx1), .busy(busy1), .word_done(wd1));
  always #5 clk = ~clk;
  assign fifo_empty = (wr == rd);
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pop0 || pop1) begin
      fifo_data <= mem[rd[5:0]];
      rd <= rd + 1;
    end
  end
  always @(negedge clk) begin
    if (pop0) begin pops0++; pop_cyc = cyc; end
    if (pop1) pops1++;
    if (wd0) wds0++;
    if (wd1) wds1++;
    if (!tx0) low0++;
    if ((pop0 || pop1) && fifo_empty) viol++;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  task automatic push(input logic [15:0] d);
    mem[wr[5:0]] = d;
    wr++;
  endtask
  function automatic logic txs(input bit sel);
    return sel ? tx1 : tx0;
  endfunction
  task automatic wait_low(input bit sel, output int t);
    int n;
    n = 0;
    while (txs(sel) !== 1'b0 && n < 1000) begin @(negedge clk); n++; end
    check("start_seen", n < 1000, 1'b1);
    t = cyc;
  endtask
  task automatic wait_wd(input bit sel);
    int n;
    n = 0;
    while ((sel ? wd1 : wd0) !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
    check("word_done_seen", n < 1000, 1'b1);
  endtask
  task automatic rx_frame(input bit sel, input logic [7:0] exp, input bit par, output int t0);
    logic [7:0] b;
    wait_low(sel, t0);
    repeat (2) @(negedge clk);
    check("start_bit", txs(sel), 1'b0);
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(negedge clk);
      b[i] = txs(sel);
    end
    check("data_byte", b, exp);
    if (par) begin
      repeat (CPB) @(negedge clk);
      check("parity_bit", txs(sel), ^exp);
    end
    repeat (CPB) @(negedge clk);
    check("stop_bit", txs(sel), 1'b1);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int t0, t1, t2, t3, p, w;
    repeat (3) @(negedge clk);
    check("rst_tx", tx0, 1'b1);
    check("rst_busy", busy0, 1'b0);
    check("rst_pop", pop0, 1'b0);
    check("rst_word_done", wd0, 1'b0);
    rst_n = 1'b1;
    // empty FIFO: stay idle
    en0 = 1'b1;
    repeat (100) @(negedge clk);
    check("empty_no_pop", pops0, 0);
    check("empty_tx_high", low0, 0);
    check("empty_busy", busy0, 1'b0);
    // single word
    push(16'hA55A);
    rx_frame(0, 8'h5A, 0, t0);
    check("pop_to_start", t0 - pop_cyc, 2);
    rx_frame(0, 8'hA5, 0, t1);
    check("frame_len", t1 - t0, 40);
    wait_wd(0);
    check("busy_at_done", busy0, 1'b1);
    @(negedge clk);
    check("busy_after_done", busy0, 1'b0);
    check("word_done_width", wd0, 1'b0);
    check("pops_word1", pops0, 1);
    check("wds_word1", wds0, 1);
    // two words back to back
    push(16'h1234);
    push(16'hBEEF);
    rx_frame(0, 8'h34, 0, t0);
    rx_frame(0, 8'h12, 0, t1);
    rx_frame(0, 8'hEF, 0, t2);
    check("word_gap", t2 - t1, 44);
    rx_frame(0, 8'hBE, 0, t3);
    en0 = 1'b0;
    repeat (20) @(negedge clk);
    check("pops_two_words", pops0, 3);
    check("wds_two_words", wds0, 3);
    // parity instance
    en1 = 1'b1;
    push(16'h075A);
    rx_frame(1, 8'h5A, 1, t0);
    rx_frame(1, 8'h07, 1, t1);
    check("parity_frame_len", t1 - t0, 44);
    wait_wd(1);
    en1 = 1'b0;
    repeat (5) @(negedge clk);
    check("parity_pops", pops1, 1);
    check("parity_busy", busy1, 1'b0);
    check("plain_pops_unchanged", pops0, 3);
    // reset midway through bit 3 of the first byte
    p = pops0;
    en0 = 1'b1;
    push(16'hC3A1);
    wait_low(0, t0);
    repeat (16 + CPB / 2) @(negedge clk);
    check("bit3_before_reset", tx0, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    check("reset_tx_immediate", tx0, 1'b1);
    check("reset_busy_immediate", busy0, 1'b0);
    push(16'h5566);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    rx_frame(0, 8'h66, 0, t0);
    rx_frame(0, 8'h55, 0, t1);
    wait_wd(0);
    repeat (5) @(negedge clk);
    check("pops_after_reset", pops0 - p, 2);
    // drop enable during the second byte
    p = pops0;
    w = wds0;
    push(16'h9A3C);
    rx_frame(0, 8'h3C, 0, t0);
    fork
      begin
        repeat (20) @(negedge clk);
        en0 = 1'b0;
        push(16'h7777);
      end
      rx_frame(0, 8'h9A, 0, t1);
    join
    wait_wd(0);
    repeat (100) @(negedge clk);
    check("disable_wds", wds0 - w, 1);
    check("disable_no_pop", pops0 - p, 1);
    check("disable_idle", busy0, 1'b0);
    check("disable_tx_high", tx0, 1'b1);
    check("no_pop_when_empty", viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
